// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcode constants and the register-slave FSM state type.
package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } tl_state_e;

endpackage

// File: rtl/tl_peri_reg_slave_if.sv
// TileLink-UL A/D channel bundle between the peripheral crossbar and a register slave.
interface tl_peri_reg_slave_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [PARAM_WIDTH-1:0]  a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic                    a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MASK_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;

  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [PARAM_WIDTH-1:0]  d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic                    d_source;
  logic                    d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

endinterface

// File: rtl/tl_peri_regfile.sv
// NUM_REGS x 32-bit register storage with byte-lane writes; index 0 reads as a fixed ID.
module tl_peri_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h7E1A_0001
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] idx_i,
  input  logic [3:0]                  mask_i,
  input  logic [31:0]                 wdata_i,
  output logic [31:0]                 rdata_o
);
  localparam int IDXW = $clog2(NUM_REGS);

  logic [31:0] mem_q [NUM_REGS];

  // Byte-lane writes; entry 0 is never written and reads come from ID_VALUE instead.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (idx_i == IDXW'(i) && mask_i[b]) mem_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Combinational read port.
  always_comb begin
    rdata_o = (idx_i == '0) ? ID_VALUE : mem_q[idx_i];
  end

endmodule

// File: rtl/tl_peri_reg_slave.sv
// TileLink-UL register slave: one request at a time, programmable wait states,
// decode/alignment/opcode errors reported on d_error. All outputs registered.
module tl_peri_reg_slave
  import tl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int                    NUM_REGS     = 16,
  parameter int                    WAIT_CYCLES  = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'h7E1A_0001
) (
  input logic                clk,
  input logic                reset,
  tl_peri_reg_slave_if.slave tl
);
  localparam int IDXW = $clog2(NUM_REGS);

  tl_state_e               state_q;
  logic [3:0]              wcnt_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic                    src_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [MASK_WIDTH-1:0]   mask_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic                    a_ready_q;
  logic                    d_valid_q;
  logic [OPCODE_WIDTH-1:0] d_opcode_q;
  logic [SIZE_WIDTH-1:0]   d_size_q;
  logic                    d_source_q;
  logic [DATA_WIDTH-1:0]   d_data_q;
  logic                    d_error_q;

  logic [IDXW-1:0] idx;
  logic            in_range, misalign, bad_size, is_get, is_put, err, wr_en;
  logic [31:0]     rdata;
  logic            unused_param;

  assign unused_param = ^tl.a_param;

  // Decode of the captured request; only consumed in EXEC.
  always_comb begin
    idx      = addr_q[IDXW+1:2];
    in_range = (addr_q[ADDR_WIDTH-1:IDXW+2] == BASE_ADDR[ADDR_WIDTH-1:IDXW+2]);
    is_get   = (op_q == OPCODE_WIDTH'(TL_GET));
    is_put   = (op_q == OPCODE_WIDTH'(TL_PUT_FULL)) || (op_q == OPCODE_WIDTH'(TL_PUT_PARTIAL));
    bad_size = (size_q > SIZE_WIDTH'(2));
    misalign = 1'b0;
    if (size_q == SIZE_WIDTH'(1))      misalign = addr_q[0];
    else if (size_q == SIZE_WIDTH'(2)) misalign = |addr_q[1:0];
    err   = !in_range || bad_size || misalign || !(is_get || is_put) || (is_put && idx == '0);
    wr_en = (state_q == ST_EXEC) && is_put && !err;
  end

  tl_peri_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_en),
    .idx_i   (idx),
    .mask_i  (mask_q),
    .wdata_i (data_q),
    .rdata_o (rdata)
  );

  // Request FSM: accept, count wait states, execute, hold the response until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      op_q       <= '0;
      size_q     <= '0;
      src_q      <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      a_ready_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= 1'b0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tl.a_valid && a_ready_q) begin
            op_q      <= tl.a_opcode;
            size_q    <= tl.a_size;
            src_q     <= tl.a_source;
            addr_q    <= tl.a_address;
            mask_q    <= tl.a_mask;
            data_q    <= tl.a_data;
            a_ready_q <= 1'b0;
            wcnt_q    <= 4'(WAIT_CYCLES);
            state_q   <= (WAIT_CYCLES == 0) ? ST_EXEC : ST_WAIT;
          end else begin
            a_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          d_valid_q  <= 1'b1;
          d_opcode_q <= is_get ? OPCODE_WIDTH'(TL_ACCESS_ACK_DATA) : OPCODE_WIDTH'(TL_ACCESS_ACK);
          d_error_q  <= err;
          d_data_q   <= (is_get && !err) ? DATA_WIDTH'(rdata) : '0;
          d_size_q   <= size_q;
          d_source_q <= src_q;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (tl.d_ready) begin
            d_valid_q <= 1'b0;
            a_ready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tl.a_ready  = a_ready_q;
  assign tl.d_valid  = d_valid_q;
  assign tl.d_opcode = d_opcode_q;
  assign tl.d_param  = PARAM_WIDTH'(0);
  assign tl.d_size   = d_size_q;
  assign tl.d_source = d_source_q;
  assign tl.d_sink   = 1'b0;
  assign tl.d_data   = d_data_q;
  assign tl.d_error  = d_error_q;

endmodule

// File: tb/tb_tl_peri_reg_slave.sv
// Randomized testbench for tl_peri_reg_slave against an address-map reference model.
module tb_tl_peri_reg_slave;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] IDV   = 32'h7E1A_0001;
  localparam int          NREGS = 16;
  localparam int          WAITC = 2;

  logic clk;
  logic reset;

  tl_peri_reg_slave_if tl_if ();

  tl_peri_reg_slave dut (
    .clk   (clk),
    .reset (reset),
    .tl    (tl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mregs [NREGS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mregs[0] = IDV;
    for (int i = 1; i < NREGS; i++) mregs[i] = '0;
  endfunction

  // Reference: outcome of a request computed directly from the address map rules.
  function automatic void model(input logic [2:0] op, input logic [2:0] size,
                                input logic [31:0] addr, input logic [3:0] mask,
                                input logic [31:0] data, output logic err,
                                output logic [2:0] dop, output logic [31:0] ddata);
    longint unsigned a;
    int unsigned idx;
    bit in_range, aligned, known_op, is_put;
    a        = longint'(addr);
    in_range = (a >= longint'(BASE)) && (a < longint'(BASE) + NREGS * 4);
    idx      = in_range ? 32'((a - longint'(BASE)) / 4) : 0;
    aligned  = (size > 3'd2) ? 1'b0 : ((a % (64'd1 << size)) == 0);
    known_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    is_put   = (op == 3'd0) || (op == 3'd1);
    err      = !in_range || (size > 3'd2) || !aligned || !known_op || (is_put && idx == 0);
    dop      = (op == 3'd4) ? 3'd1 : 3'd0;
    ddata    = '0;
    if (!err) begin
      if (op == 3'd4) ddata = mregs[idx];
      else
        for (int b = 0; b < 4; b++)
          if (mask[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  task automatic chk_d(input string tag, input logic err, input logic [2:0] dop,
                       input logic [31:0] ddata, input logic [2:0] size, input logic src);
    chk({tag, "_dvalid"}, 32'(tl_if.d_valid), 1);
    chk({tag, "_aready_low"}, 32'(tl_if.a_ready), 0);
    chk({tag, "_dopcode"}, 32'(tl_if.d_opcode), 32'(dop));
    chk({tag, "_ddata"}, tl_if.d_data, ddata);
    chk({tag, "_derror"}, 32'(tl_if.d_error), 32'(err));
    chk({tag, "_dsize"}, 32'(tl_if.d_size), 32'(size));
    chk({tag, "_dsource"}, 32'(tl_if.d_source), 32'(src));
    chk({tag, "_dparam_sink"}, {28'(tl_if.d_param), 4'(tl_if.d_sink)}, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aready"}, 32'(tl_if.a_ready), 0);
    chk({tag, "_dvalid"}, 32'(tl_if.d_valid), 0);
    chk({tag, "_dopcode"}, 32'(tl_if.d_opcode), 0);
    chk({tag, "_ddata"}, tl_if.d_data, 0);
    chk({tag, "_derror"}, 32'(tl_if.d_error), 0);
    chk({tag, "_dsize_src"}, {28'(tl_if.d_size), 4'(tl_if.d_source)}, 0);
  endtask

  // Drives one request, checks latency, response fields (stable while d_ready is low),
  // and that a_ready returns only after the D handshake.
  task automatic txn(input string tag, input logic [2:0] op, input logic [2:0] size,
                     input logic src, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input int hold);
    logic e_err;
    logic [2:0] e_op;
    logic [31:0] e_data;
    bit ok;
    int lat;
    model(op, size, addr, mask, data, e_err, e_op, e_data);
    tl_if.a_valid   = 1'b1;
    tl_if.a_opcode  = op;
    tl_if.a_param   = 3'($urandom);
    tl_if.a_size    = size;
    tl_if.a_source  = src;
    tl_if.a_address = addr;
    tl_if.a_mask    = mask;
    tl_if.a_data    = data;
    tl_if.d_ready   = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tl_if.a_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_accept"}, 32'(ok), 1);
    if (!ok) begin tl_if.a_valid = 1'b0; return; end
    @(posedge clk); #1;
    tl_if.a_valid   = 1'b0;
    tl_if.a_opcode  = 3'($urandom);
    tl_if.a_size    = 3'($urandom);
    tl_if.a_source  = 1'($urandom);
    tl_if.a_address = $urandom;
    tl_if.a_mask    = 4'($urandom);
    tl_if.a_data    = $urandom;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (tl_if.d_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_dvalid_seen"}, 32'(ok), 1);
    if (!ok) return;
    chk({tag, "_latency"}, lat, WAITC + 1);
    chk_d(tag, e_err, e_op, e_data, size, src);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_d({tag, "_hold"}, e_err, e_op, e_data, size, src);
    end
    tl_if.d_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_dvalid_drop"}, 32'(tl_if.d_valid), 0);
    chk({tag, "_aready_back"}, 32'(tl_if.a_ready), 1);
    tl_if.d_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op, size;
    logic [31:0] addr;
    int r;
    reset = 1'b1;
    tl_if.a_valid = 1'b0; tl_if.a_opcode = '0; tl_if.a_param = '0; tl_if.a_size = '0;
    tl_if.a_source = 1'b0; tl_if.a_address = '0; tl_if.a_mask = '0; tl_if.a_data = '0;
    tl_if.d_ready = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk({"reset_release_aready"}, 32'(tl_if.a_ready), 0);
    @(posedge clk); #1;
    chk("idle_aready", 32'(tl_if.a_ready), 1);

    // Directed cases
    txn("get_id",      3'd4, 3'd2, 1'b0, 32'h1000_0000, 4'hF, 32'h0,          0);
    txn("putfull_r2",  3'd0, 3'd2, 1'b0, 32'h1000_0008, 4'hF, 32'hDEAD_BEEF,   0);
    txn("get_r2",      3'd4, 3'd2, 1'b0, 32'h1000_0008, 4'hF, 32'h0,          0);
    txn("putpart_r2",  3'd1, 3'd2, 1'b0, 32'h1000_0008, 4'h2, 32'h0000_5500,  0);
    txn("get_r2_part", 3'd4, 3'd2, 1'b0, 32'h1000_0008, 4'hF, 32'h0,          0);
    txn("err_range",   3'd4, 3'd2, 1'b0, 32'h1000_0040, 4'hF, 32'h0,          0);
    txn("err_put_id",  3'd0, 3'd2, 1'b0, 32'h1000_0000, 4'hF, 32'h1234_5678,  0);
    txn("err_align",   3'd0, 3'd2, 1'b0, 32'h1000_0006, 4'hF, 32'h1111_1111,  0);
    txn("err_opcode",  3'd2, 3'd2, 1'b0, 32'h1000_0008, 4'hF, 32'h2222_2222,  0);
    txn("err_size",    3'd4, 3'd3, 1'b0, 32'h1000_0008, 4'hF, 32'h0,          0);
    txn("mask0_noop",  3'd1, 3'd2, 1'b0, 32'h1000_0008, 4'h0, 32'hFFFF_FFFF,  0);
    txn("get_r2_keep", 3'd4, 3'd2, 1'b0, 32'h1000_0008, 4'hF, 32'h0,          0);
    txn("hold10_src1", 3'd4, 3'd2, 1'b1, 32'h1000_0008, 4'hF, 32'h0,          10);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      op = (r < 4) ? 3'd4 : (r < 6) ? 3'd0 : (r < 9) ? 3'd1 : 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      size = (r < 7) ? 3'd2 : 3'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      addr = (r < 8) ? BASE + $urandom_range(0, 63)
           : (r == 8) ? BASE + 32'd64 + $urandom_range(0, 15) : BASE - 32'd4;
      if (size == 3'd2 && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      txn("rand", op, size, 1'($urandom), addr, 4'($urandom), $urandom,
          int'($urandom_range(0, 3)));
    end

    // Reset while a Put sits in its wait states: no D beat, no write, registers cleared
    txn("pre_rst_get", 3'd4, 3'd2, 1'b1, 32'h1000_0008, 4'hF, 32'h0, 0);
    tl_if.a_valid = 1'b1; tl_if.a_opcode = 3'd0; tl_if.a_size = 3'd2; tl_if.a_source = 1'b1;
    tl_if.a_address = 32'h1000_000C; tl_if.a_mask = 4'hF; tl_if.a_data = 32'hCAFE_F00D;
    for (int i = 0; i < 20 && !tl_if.a_ready; i++) begin @(posedge clk); #1; end
    chk("rst_mid_accept", 32'(tl_if.a_ready), 1);
    @(posedge clk); #1;
    tl_if.a_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_no_dbeat", 32'(tl_if.d_valid), 0);
    end
    txn("post_rst_get_r3", 3'd4, 3'd2, 1'b0, 32'h1000_000C, 4'hF, 32'h0,         0);
    txn("post_rst_get_r2", 3'd4, 3'd2, 1'b0, 32'h1000_0008, 4'hF, 32'h0,         0);
    txn("post_rst_put",    3'd0, 3'd2, 1'b1, 32'h1000_003C, 4'hF, 32'hA5A5_5A5A, 0);
    txn("post_rst_get",    3'd4, 3'd2, 1'b0, 32'h1000_003C, 4'hF, 32'h0,         1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
